// File: rtl/mul_hilo_if.sv
// Execute-stage multiply/HI-LO bus between the pipeline (master) and mul_hilo (slave).
// state_dbg exposes the multiplier FSM state (0 IDLE, 1 MUL, 2 DONE) for observers.
interface mul_hilo_if;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] aluOut;
  logic [1:0]  sel;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  // start is a level request taken only while idle; busy covers the 32
  // iteration cycles and done pulses for exactly one cycle when HI/LO update.
  modport master (
    output start, dataA, dataB, aluOut, sel,
    input  dataOut, busy, done, state_dbg
  );

  modport slave (
    input  start, dataA, dataB, aluOut, sel,
    output dataOut, busy, done, state_dbg
  );
endinterface

// File: rtl/mul_hilo.sv
// 32x32 -> 64 shift-add multiplier with HI/LO result registers and result mux.
// Define MUL_SIGNED_EN for two's-complement operands (magnitude multiply + final negate).
module mul_hilo (
  input  logic          clk,
  input  logic          rst,
  mul_hilo_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q,  prod_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [32:0] sum;
  logic [63:0] result;
`ifdef MUL_SIGNED_EN
  logic        sign_q, sign_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MUL_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MUL_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = '0;
    result  = '0;
`ifdef MUL_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = MUL;
          cnt_d   = '0;
`ifdef MUL_SIGNED_EN
          mcand_d = bus.dataA[31] ? (~bus.dataA + 32'd1) : bus.dataA;
          prod_d  = {32'd0, (bus.dataB[31] ? (~bus.dataB + 32'd1) : bus.dataB)};
          sign_d  = bus.dataA[31] ^ bus.dataB[31];
`else
          mcand_d = bus.dataA;
          prod_d  = {32'd0, bus.dataB};
`endif
        end
      end
      MUL: begin
        // Carry out of the upper-half add is shifted back in as the new bit 63.
        sum    = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod_d = {sum, prod_q[31:1]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
`ifdef MUL_SIGNED_EN
          result = sign_q ? (~prod_d + 64'd1) : prod_d;
`else
          result = prod_d;
`endif
          hi_d    = result[63:32];
          lo_d    = result[31:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (bus.sel)
      2'b01:   bus.dataOut = hi_q;
      2'b10:   bus.dataOut = lo_q;
      default: bus.dataOut = bus.aluOut;
    endcase
  end

  assign bus.busy      = (state_q == MUL);
  assign bus.done      = (state_q == DONE);
  assign bus.state_dbg = state_q;

endmodule

// File: doc/mul_hilo.md
MUL_HILO -- requirements
Module: mul_hilo

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request one multiply; sampled only in IDLE.
REQ-004 SHALL have port dataA, input, 32 bits: multiplicand (rs), captured with start.
REQ-005 SHALL have port dataB, input, 32 bits: multiplier (rt), captured with start.
REQ-006 SHALL have port aluOut, input, 32 bits: ALU result forwarded to dataOut.
REQ-007 SHALL have port sel, input, 2 bits: 00 = aluOut, 01 = HI, 10 = LO, 11 = aluOut.
REQ-008 SHALL have port dataOut, output, 32 bits: execute-stage result, combinational mux of aluOut, HI and LO per sel.
REQ-009 SHALL have port busy, output, 1 bit: high while in MUL.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, high in DONE.

Function
REQ-011 SHALL implement three states: IDLE, MUL and DONE.
REQ-012 SHALL make the following transitions:
- IDLE to MUL on the edge where start=1.
- MUL to DONE after 32 iterations.
- DONE to IDLE unconditionally on the next edge.
REQ-013 SHALL, on the edge that accepts start, latch dataA as a 32-bit multiplicand and dataB as the low half of a 64-bit product register, clear the upper half, and clear a 6-bit counter.
REQ-014 SHALL perform one shift-add iteration per MUL edge:
- If product[0]=1, add the multiplicand to product[63:32] using a 33-bit sum that keeps the carry.
- Then shift {carry, product} right by 1.
- Then increment the counter.
REQ-015 SHALL, on the 32nd MUL edge, write product[63:32] to HI and product[31:0] to LO, and enter DONE.
REQ-016 SHALL meet this latency: start accepted at edge E0; busy high from E0 to E32 (32 cycles); done high from E32 to E33; new HI/LO visible on dataOut from E32.
REQ-017 SHALL ignore start in MUL and DONE; no queuing and no restart.
REQ-018 SHALL hold the previous HI/LO values during MUL; reading sel=01/10 while busy returns the old result.
REQ-019 SHALL pass aluOut to dataOut for sel=00/11 in every state, with zero latency.
REQ-020 SHALL ignore dataA and dataB changes after start is accepted.
REQ-021 SHALL let the 64-bit product register wrap modulo 2^64; no overflow flag.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, force the following:
- state = IDLE; busy = 0; done = 0.
- HI = 0; LO = 0; counter = 0; product register = 0.
REQ-023 SHALL give rst priority over start and over any in-flight iteration; reset mid-multiply aborts with no done pulse and no HI/LO write.
REQ-024 SHALL drive dataOut after reset to aluOut for sel=00/11 and to 0 for sel=01/10.

Configuration
REQ-025 SHALL support macro MUL_SIGNED_EN.
REQ-026 SHALL, when MUL_SIGNED_EN is defined:
- Treat operands as two's complement.
- At start, latch |dataA| and |dataB| and the sign dataA[31]^dataB[31].
- At the HI/LO write, negate the 64-bit product if the sign is 1.
- Keep latency unchanged.
REQ-027 SHALL, when MUL_SIGNED_EN is undefined, treat operands as unsigned and contain no sign logic.

Verification
REQ-028 SHALL cover: rst=1 for 2 cycles, sel=01 then 10 -> dataOut=0x00000000; busy=0; done=0.
REQ-029 SHALL cover: start with 3 x 5 -> busy high 32 cycles; done pulse 32 cycles after acceptance; HI=0x00000000; LO=0x0000000F.
REQ-030 SHALL cover: start with 0xFFFFFFFF x 0xFFFFFFFF (unsigned build) -> HI=0xFFFFFFFE; LO=0x00000001.
REQ-031 SHALL cover: second start at MUL cycle 5 with 2 x 2 -> ignored; first result 7 x 6 gives LO=0x0000002A.
REQ-032 SHALL cover: rst at MUL cycle 10 -> busy=0 next cycle; no done pulse; HI=LO=0.
REQ-033 SHALL cover: 0xFFFFFFFD x 7 -> with MUL_SIGNED_EN: HI=0xFFFFFFFF, LO=0xFFFFFFEB; without: HI=0x00000006, LO=0xFFFFFFEB; sel=00 with aluOut=0x1234 while busy gives dataOut=0x1234.
